reaction_ctrl: RTL

REACTION_CTRL -- requirements
Module: reaction_ctrl

---
 rtl/reaction_ctrl_if.sv | 30 +++
 rtl/reaction_ctrl.sv | 126 ++++++++++++
 2 files changed

// File: rtl/reaction_ctrl_if.sv
// Bus bundle for reaction_ctrl: the player-facing controls and the round/result outputs.
// Exposes a master view for the driver and a slave view for the controller.
interface reaction_ctrl_if #(
   parameter int unsigned N_PLAYERS = 2,
   parameter int unsigned CNT_W     = 16
);
   localparam int unsigned WIN_W = (N_PLAYERS > 1) ? $clog2(N_PLAYERS) : 1;

   logic                 tick;
   logic                 start_n;
   logic [N_PLAYERS-1:0] stop_n;
   logic                 clear;
   logic [CNT_W-1:0]     delay;
   logic [2:0]           state;
   logic [CNT_W-1:0]     rt;
   logic [WIN_W-1:0]     winner;
   logic                 timeout;
   logic [CNT_W-1:0]     best;
   logic                 new_best;

   modport master (
      output tick, start_n, stop_n, clear, delay,
      input  state, rt, winner, timeout, best, new_best
   );

   modport slave (
      input  tick, start_n, stop_n, clear, delay,
      output state, rt, winner, timeout, best, new_best
   );
endinterface

// File: rtl/reaction_ctrl.sv
// Multi-player reaction-time game controller: random-ish countdown, foul detection,
// reaction timing with timeout, and a best-time record kept until reset.
module reaction_ctrl #(
   parameter int unsigned N_PLAYERS = 2,
   parameter int unsigned CNT_W     = 16,
   parameter int unsigned TIMEOUT   = 2000
) (
   input logic             clk,
   input logic             reset,
   reaction_ctrl_if.slave  bus
);
   localparam int unsigned WIN_W = (N_PLAYERS > 1) ? $clog2(N_PLAYERS) : 1;
   localparam logic [CNT_W-1:0] RT_LAST = CNT_W'(TIMEOUT - 1);

   typedef enum logic [2:0] {
      StIdle      = 3'd0,
      StCountdown = 3'd1,
      StReaction  = 3'd2,
      StDisplay   = 3'd3,
      StFoul      = 3'd4
   } state_e;

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] rt_q, rt_d;
   logic [WIN_W-1:0] winner_q, winner_d;
   logic             timeout_q, timeout_d;
   logic [CNT_W-1:0] best_q, best_d;
   logic             new_best_q, new_best_d;

   logic             any_press;
   logic [WIN_W-1:0] press_idx;

   // Scan high to low so the lowest pressed index is the one left standing.
   always_comb begin
      any_press = 1'b0;
      press_idx = '0;
      for (int i = N_PLAYERS - 1; i >= 0; i--) begin
         if (!bus.stop_n[i]) begin
            any_press = 1'b1;
            press_idx = WIN_W'(i);
         end
      end
   end

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      rt_d       = rt_q;
      winner_d   = winner_q;
      timeout_d  = timeout_q;
      best_d     = best_q;
      new_best_d = 1'b0;
      case (state_q)
         StIdle: begin
            if (!bus.start_n) begin
               state_d   = StCountdown;
               cnt_d     = bus.delay;
               rt_d      = '0;
               timeout_d = 1'b0;
               winner_d  = '0;
            end
         end
         StCountdown: begin
            if (any_press) begin
               state_d  = StFoul;
               winner_d = press_idx;
            end else if (cnt_q == '0) begin
               if (bus.start_n) state_d = StReaction;
            end else if (bus.tick) begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         StReaction: begin
            // A press beats both the tick and the timeout in the same cycle.
            if (any_press) begin
               state_d  = StDisplay;
               winner_d = press_idx;
               if (rt_q < best_q) begin
                  best_d     = rt_q;
                  new_best_d = 1'b1;
               end
            end else if (bus.tick) begin
               rt_d = rt_q + 1'b1;
               if (rt_q == RT_LAST) begin
                  state_d   = StDisplay;
                  timeout_d = 1'b1;
                  winner_d  = '0;
               end
            end
         end
         StDisplay, StFoul: begin
            if (bus.clear) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= StIdle;
         cnt_q      <= '0;
         rt_q       <= '0;
         winner_q   <= '0;
         timeout_q  <= 1'b0;
         best_q     <= '1;
         new_best_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         rt_q       <= rt_d;
         winner_q   <= winner_d;
         timeout_q  <= timeout_d;
         best_q     <= best_d;
         new_best_q <= new_best_d;
      end
   end

   assign bus.state    = state_q;
   assign bus.rt       = rt_q;
   assign bus.winner   = winner_q;
   assign bus.timeout  = timeout_q;
   assign bus.best     = best_q;
   assign bus.new_best = new_best_q;

endmodule
